// File: rtl/uart_rx.sv
// 8N1 serial receiver: two-flop input synchronizer, mid-bit sampling, one-cycle
// strobes for good bytes and framing errors. All outputs are registered.
//
// state            | meaning
// s_IDLE           | line idle, waiting for a low level on rx
// s_RX_START_BIT   | counting to mid start bit, rejecting glitches
// s_RX_DATA_BITS   | sampling 8 data bits, LSB first, one per bit period
// s_RX_STOP_BIT    | sampling the stop bit; good byte or framing error
// s_CLEANUP        | one cycle after a good byte while o_Rx_DV is high
// s_WAIT_IDLE      | after a framing error, wait for the line to return high
module uart_rx #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       i_Clock,
    input  logic       i_Rst_n,
    input  logic       i_Rx_Serial,
    output logic       o_Rx_DV,
    output logic [7:0] o_Rx_Byte,
    output logic       o_Rx_Frame_Err,
    output logic       o_Rx_Active
);

    localparam logic [6:0] HALF_BIT = 7'((CLKS_PER_BIT - 1) / 2);
    localparam logic [6:0] LAST_CLK = 7'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        s_IDLE         = 3'd0,
        s_RX_START_BIT = 3'd1,
        s_RX_DATA_BITS = 3'd2,
        s_RX_STOP_BIT  = 3'd3,
        s_CLEANUP      = 3'd4,
        s_WAIT_IDLE    = 3'd5
    } state_t;

    state_t     state;
    logic       rx_meta;
    logic       rx;
    logic [6:0] clk_count;
    logic [2:0] bit_index;
    logic [7:0] rx_shift;

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            rx_meta <= 1'b1;
            rx      <= 1'b1;
        end else begin
            rx_meta <= i_Rx_Serial;
            rx      <= rx_meta;
        end
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state          <= s_IDLE;
            clk_count      <= 7'd0;
            bit_index      <= 3'd0;
            rx_shift       <= 8'h00;
            o_Rx_DV        <= 1'b0;
            o_Rx_Byte      <= 8'h00;
            o_Rx_Frame_Err <= 1'b0;
            o_Rx_Active    <= 1'b0;
        end else begin
            // Strobes default low so each lasts exactly one cycle.
            o_Rx_DV        <= 1'b0;
            o_Rx_Frame_Err <= 1'b0;
            case (state)
                s_IDLE: begin
                    clk_count <= 7'd0;
                    bit_index <= 3'd0;
                    if (!rx) begin
                        state       <= s_RX_START_BIT;
                        o_Rx_Active <= 1'b1;
                    end
                end

                s_RX_START_BIT: begin
                    if (clk_count == HALF_BIT) begin
                        clk_count <= 7'd0;
                        if (!rx) begin
                            state <= s_RX_DATA_BITS;
                        end else begin
                            state       <= s_IDLE;
                            o_Rx_Active <= 1'b0;
                        end
                    end else begin
                        clk_count <= clk_count + 7'd1;
                    end
                end

                s_RX_DATA_BITS: begin
                    if (clk_count == LAST_CLK) begin
                        clk_count           <= 7'd0;
                        rx_shift[bit_index] <= rx;
                        if (bit_index == 3'd7) begin
                            bit_index <= 3'd0;
                            state     <= s_RX_STOP_BIT;
                        end else begin
                            bit_index <= bit_index + 3'd1;
                        end
                    end else begin
                        clk_count <= clk_count + 7'd1;
                    end
                end

                s_RX_STOP_BIT: begin
                    if (clk_count == LAST_CLK) begin
                        clk_count   <= 7'd0;
                        o_Rx_Active <= 1'b0;
                        if (rx) begin
                            o_Rx_Byte <= rx_shift;
                            o_Rx_DV   <= 1'b1;
                            state     <= s_CLEANUP;
                        end else begin
                            o_Rx_Frame_Err <= 1'b1;
                            state          <= s_WAIT_IDLE;
                        end
                    end else begin
                        clk_count <= clk_count + 7'd1;
                    end
                end

                s_CLEANUP: begin
                    state <= s_IDLE;
                end

                // A held-low break stays here so it yields only one error pulse.
                s_WAIT_IDLE: begin
                    if (rx) begin
                        state <= s_IDLE;
                    end
                end

                default: begin
                    state       <= s_IDLE;
                    clk_count   <= 7'd0;
                    bit_index   <= 3'd0;
                    o_Rx_Active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table-driven single frames plus hand-written
// back-to-back, glitch, break, mid-frame reset and loopback sequences.
module tb_uart_rx;

    localparam int CPB  = 87;
    localparam int CPB4 = 4;

    logic       i_Clock = 1'b0;
    logic       i_Rst_n = 1'b0;
    logic       rx_line = 1'b1;
    logic       rx_line4 = 1'b1;
    logic       dv, ferr, active;
    logic [7:0] rx_byte;
    logic       dv4, ferr4, active4;
    logic [7:0] rx_byte4;

    always #5 i_Clock = ~i_Clock;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .i_Clock        (i_Clock),
        .i_Rst_n        (i_Rst_n),
        .i_Rx_Serial    (rx_line),
        .o_Rx_DV        (dv),
        .o_Rx_Byte      (rx_byte),
        .o_Rx_Frame_Err (ferr),
        .o_Rx_Active    (active)
    );

    uart_rx #(.CLKS_PER_BIT(CPB4)) dut4 (
        .i_Clock        (i_Clock),
        .i_Rst_n        (i_Rst_n),
        .i_Rx_Serial    (rx_line4),
        .o_Rx_DV        (dv4),
        .o_Rx_Byte      (rx_byte4),
        .o_Rx_Frame_Err (ferr4),
        .o_Rx_Active    (active4)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    int         cyc = 0;
    logic [7:0] dv_q[$];
    int         dv_t[$];
    logic [7:0] dv4_q[$];
    int         ferr_cnt = 0, ferr4_cnt = 0, act_cnt = 0;
    int         width_viol = 0, both_viol = 0;
    logic       prev_dv = 1'b0, prev_dv4 = 1'b0;

    always @(posedge i_Clock) cyc <= cyc + 1;

    always @(negedge i_Clock) begin
        if (dv) begin
            dv_q.push_back(rx_byte);
            dv_t.push_back(cyc);
        end
        if (dv4) dv4_q.push_back(rx_byte4);
        if (ferr) ferr_cnt++;
        if (ferr4) ferr4_cnt++;
        if (active) act_cnt++;
        if ((dv && prev_dv) || (dv4 && prev_dv4)) width_viol++;
        if ((dv && ferr) || (dv4 && ferr4)) both_viol++;
        prev_dv  = dv;
        prev_dv4 = dv4;
    end

    task automatic set_line(input int sel, input logic v);
        if (sel == 0) rx_line = v;
        else rx_line4 = v;
    endtask

    task automatic idle(input int sel, input int n);
        set_line(sel, 1'b1);
        repeat (n) @(negedge i_Clock);
    endtask

    task automatic send_frame(input int sel, input logic [7:0] d, input logic stop);
        int cpb;
        logic [9:0] bits;
        cpb  = (sel == 0) ? CPB : CPB4;
        bits = {stop, d, 1'b0};
        for (int b = 0; b < 10; b++) begin
            set_line(sel, bits[b]);
            repeat (cpb) @(negedge i_Clock);
        end
        set_line(sel, 1'b1);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_dv;
        logic [7:0] exp_byte;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached, expected run to finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, f0, a0, base;
        logic [7:0] sent[$];
        logic [7:0] b;

        vecs[0] = '{8'h5A, 1'b1, 1, 8'h5A, 0};
        vecs[1] = '{8'h00, 1'b1, 1, 8'h00, 0};
        vecs[2] = '{8'hFF, 1'b1, 1, 8'hFF, 0};
        vecs[3] = '{8'h81, 1'b1, 1, 8'h81, 0};
        vecs[4] = '{8'h77, 1'b0, 0, 8'h81, 1};
        vecs[5] = '{8'h3C, 1'b1, 1, 8'h3C, 0};

        repeat (3) @(negedge i_Clock);
        check("reset_dv", dv, 0);
        check("reset_byte", rx_byte, 8'h00);
        check("reset_ferr", ferr, 0);
        check("reset_active", active, 0);
        i_Rst_n = 1'b1;
        idle(0, 20);

        // Single frames from the table; active spans cycle 0 .. stop sample (827 cycles).
        for (int i = 0; i < 6; i++) begin
            d0 = dv_q.size(); f0 = ferr_cnt; a0 = act_cnt;
            send_frame(0, vecs[i].data, vecs[i].stop);
            idle(0, 30);
            check($sformatf("vec%0d_dv_count", i), dv_q.size() - d0, vecs[i].exp_dv);
            check($sformatf("vec%0d_byte", i), rx_byte, vecs[i].exp_byte);
            check($sformatf("vec%0d_ferr_count", i), ferr_cnt - f0, vecs[i].exp_ferr);
            check($sformatf("vec%0d_active_cycles", i), act_cnt - a0, 827);
            if (vecs[i].exp_dv == 1 && dv_q.size() > d0)
                check($sformatf("vec%0d_dv_byte", i), dv_q[d0], vecs[i].exp_byte);
        end

        // Back-to-back frames, no gap: DV pulses exactly one frame (870 clocks) apart.
        d0 = dv_q.size();
        send_frame(0, 8'h00, 1'b1);
        send_frame(0, 8'hFF, 1'b1);
        send_frame(0, 8'hA5, 1'b1);
        idle(0, 30);
        check("b2b_count", dv_q.size() - d0, 3);
        if (dv_q.size() - d0 == 3) begin
            check("b2b_byte0", dv_q[d0], 8'h00);
            check("b2b_byte1", dv_q[d0+1], 8'hFF);
            check("b2b_byte2", dv_q[d0+2], 8'hA5);
            check("b2b_space01", dv_t[d0+1] - dv_t[d0], 10 * CPB);
            check("b2b_space12", dv_t[d0+2] - dv_t[d0+1], 10 * CPB);
        end

        // Glitch: 20 low cycles, rejected at the start check (edge 44).
        d0 = dv_q.size(); f0 = ferr_cnt; a0 = act_cnt;
        set_line(0, 1'b0);
        repeat (20) @(negedge i_Clock);
        idle(0, 100);
        check("glitch_dv", dv_q.size() - d0, 0);
        check("glitch_ferr", ferr_cnt - f0, 0);
        check("glitch_active_cycles", act_cnt - a0, 44);
        check("glitch_active_low", active, 0);
        send_frame(0, 8'h3C, 1'b1);
        idle(0, 30);
        check("glitch_next_count", dv_q.size() - d0, 1);
        check("glitch_next_byte", rx_byte, 8'h3C);

        // Framing error followed by a long break: exactly one error pulse.
        send_frame(0, 8'h11, 1'b1);
        idle(0, 30);
        d0 = dv_q.size(); f0 = ferr_cnt;
        send_frame(0, 8'h77, 1'b0);
        set_line(0, 1'b0);
        repeat (500) @(negedge i_Clock);
        idle(0, 2 * CPB);
        check("break_ferr_count", ferr_cnt - f0, 1);
        check("break_dv_count", dv_q.size() - d0, 0);
        check("break_byte_held", rx_byte, 8'h11);
        send_frame(0, 8'h22, 1'b1);
        idle(0, 30);
        check("break_next_count", dv_q.size() - d0, 1);
        check("break_next_byte", rx_byte, 8'h22);
        check("break_ferr_after", ferr_cnt - f0, 1);

        // Reset during data bit 4 of 0x99.
        d0 = dv_q.size();
        set_line(0, 1'b0);
        repeat (CPB) @(negedge i_Clock);
        for (int k = 0; k < 4; k++) begin
            b = 8'h99;
            set_line(0, b[k]);
            repeat (CPB) @(negedge i_Clock);
        end
        set_line(0, 1'b1);
        repeat (40) @(negedge i_Clock);
        i_Rst_n = 1'b0;
        repeat (3) @(negedge i_Clock);
        check("rst_mid_dv", dv, 0);
        check("rst_mid_byte", rx_byte, 8'h00);
        check("rst_mid_ferr", ferr, 0);
        check("rst_mid_active", active, 0);
        i_Rst_n = 1'b1;
        idle(0, 2 * CPB);
        check("rst_mid_no_dv", dv_q.size() - d0, 0);
        send_frame(0, 8'hC3, 1'b1);
        idle(0, 30);
        check("rst_next_count", dv_q.size() - d0, 1);
        check("rst_next_byte", rx_byte, 8'hC3);

        // Loopback at 87 clocks/bit: back-to-back random bytes.
        base = dv_q.size(); f0 = ferr_cnt;
        sent.delete();
        for (int i = 0; i < 24; i++) begin
            b = 8'($urandom_range(0, 255));
            sent.push_back(b);
            send_frame(0, b, 1'b1);
        end
        idle(0, 30);
        check("lb87_count", dv_q.size() - base, 24);
        check("lb87_ferr", ferr_cnt - f0, 0);
        if (dv_q.size() - base == 24)
            for (int i = 0; i < 24; i++)
                check($sformatf("lb87_byte%0d", i), dv_q[base+i], sent[i]);

        // Loopback at 4 clocks/bit: 256 back-to-back random bytes.
        base = dv4_q.size(); f0 = ferr4_cnt;
        sent.delete();
        for (int i = 0; i < 256; i++) begin
            b = 8'($urandom_range(0, 255));
            sent.push_back(b);
            send_frame(1, b, 1'b1);
        end
        idle(1, 20);
        check("lb4_count", dv4_q.size() - base, 256);
        check("lb4_ferr", ferr4_cnt - f0, 0);
        if (dv4_q.size() - base == 256)
            for (int i = 0; i < 256; i++)
                check($sformatf("lb4_byte%0d", i), dv4_q[base+i], sent[i]);

        check("dv_width_violations", width_viol, 0);
        check("dv_ferr_overlap", both_viol, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
